conv1d_mem_arbiter: RTL and testbench

Cycle-level arbiter for the conv1d accelerator's single-port internal SRAM (128 × 32-bit). It shares the SRAM between two requesters: the accelerator datapath and the external OBI-to-SRAM bridge (host CPU/DMA). It issues same-cycle grants, routes one-cycle-latency responses back to whichever requester was granted, and gives the accelerator exclusive access while `lock_i` is high. It replaces the ad-hoc `ext_mem_gnt` multiplexing in the conv1d top level.

---
 rtl/conv1d_mem_arbiter.sv | 124 ++++++++++++
 tb/tb_conv1d_mem_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv1d_mem_arbiter.sv
// rtl/conv1d_mem_arbiter.sv - two-requester arbiter for the conv1d single-port SRAM
//   clk_i, rst_ni        : clock, synchronous active-low reset
//   lock_i               : accelerator exclusive mode
//   acc_* / ext_*        : accelerator and external (OBI bridge) request/grant/response ports
//   mem_*                : SRAM request side, mem_rdata_i valid one cycle after the request
//   clr_stats_i          : clears stall_cnt_o
//   stall_cnt_o          : saturating count of cycles the external requester waited
module conv1d_mem_arbiter #(
    parameter int AddrWidth = 7,
    parameter int DataWidth = 32,
    parameter int MaxWait   = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   lock_i,
    input  logic                   acc_req_i,
    input  logic                   acc_we_i,
    input  logic [DataWidth/8-1:0] acc_be_i,
    input  logic [AddrWidth-1:0]   acc_addr_i,
    input  logic [DataWidth-1:0]   acc_wdata_i,
    output logic                   acc_gnt_o,
    output logic                   acc_rvalid_o,
    output logic [DataWidth-1:0]   acc_rdata_o,
    input  logic                   ext_req_i,
    input  logic                   ext_we_i,
    input  logic [DataWidth/8-1:0] ext_be_i,
    input  logic [AddrWidth-1:0]   ext_addr_i,
    input  logic [DataWidth-1:0]   ext_wdata_i,
    output logic                   ext_gnt_o,
    output logic                   ext_rvalid_o,
    output logic [DataWidth-1:0]   ext_rdata_o,
    output logic                   mem_req_o,
    output logic                   mem_we_o,
    output logic [DataWidth/8-1:0] mem_be_o,
    output logic [AddrWidth-1:0]   mem_addr_o,
    output logic [DataWidth-1:0]   mem_wdata_o,
    input  logic [DataWidth-1:0]   mem_rdata_i,
    input  logic                   clr_stats_i,
    output logic [15:0]            stall_cnt_o
);

    localparam logic [3:0] WaitLimit = 4'(MaxWait);

    logic [3:0]  wait_q;
    logic        rsp_acc_q;
    logic        rsp_ext_q;
    logic [15:0] stall_q;
    logic        ext_stall;

    // Grants depend only on requests, lock and wait_q; mem_rdata_i never feeds them.
    always_comb begin
        acc_gnt_o = 1'b0;
        ext_gnt_o = 1'b0;
        if (rst_ni) begin
            if (lock_i) begin
                acc_gnt_o = acc_req_i;
            end else if (acc_req_i && ext_req_i) begin
                // The external side has waited long enough: it takes this cycle.
                if (wait_q >= WaitLimit) begin
                    ext_gnt_o = 1'b1;
                end else begin
                    acc_gnt_o = 1'b1;
                end
            end else begin
                acc_gnt_o = acc_req_i;
                ext_gnt_o = ext_req_i;
            end
        end
    end

    assign ext_stall = ext_req_i & ~ext_gnt_o;

    always_comb begin
        mem_req_o   = acc_gnt_o | ext_gnt_o;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (acc_gnt_o) begin
            mem_we_o    = acc_we_i;
            mem_be_o    = acc_be_i;
            mem_addr_o  = acc_addr_i;
            mem_wdata_o = acc_wdata_i;
        end else if (ext_gnt_o) begin
            mem_we_o    = ext_we_i;
            mem_be_o    = ext_be_i;
            mem_addr_o  = ext_addr_i;
            mem_wdata_o = ext_wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wait_q    <= '0;
            rsp_acc_q <= 1'b0;
            rsp_ext_q <= 1'b0;
            stall_q   <= '0;
        end else begin
            rsp_acc_q <= acc_gnt_o;
            rsp_ext_q <= ext_gnt_o;

            if (lock_i || ext_gnt_o) begin
                wait_q <= '0;
            end else if (ext_req_i && (wait_q < WaitLimit)) begin
                wait_q <= wait_q + 4'd1;
            end

            if (clr_stats_i) begin
                stall_q <= '0;
            end else if (ext_stall && (stall_q != 16'hFFFF)) begin
                stall_q <= stall_q + 16'd1;
            end
        end
    end

    // A response registered just before reset asserts is dropped rather than
    // delivered into a requester that is itself being reset.
    assign acc_rvalid_o = rsp_acc_q & rst_ni;
    assign ext_rvalid_o = rsp_ext_q & rst_ni;
    assign acc_rdata_o  = acc_rvalid_o ? mem_rdata_i : '0;
    assign ext_rdata_o  = ext_rvalid_o ? mem_rdata_i : '0;
    assign stall_cnt_o  = stall_q;

endmodule

// File: tb/tb_conv1d_mem_arbiter.sv
// tb/tb_conv1d_mem_arbiter.sv - scoreboard bench for conv1d_mem_arbiter
module tb_conv1d_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        lock_i = 1'b0;
    logic        acc_req_i = 1'b0, acc_we_i = 1'b0;
    logic [3:0]  acc_be_i = 4'hF;
    logic [6:0]  acc_addr_i = '0;
    logic [31:0] acc_wdata_i = '0;
    logic        acc_gnt_o, acc_rvalid_o;
    logic [31:0] acc_rdata_o;
    logic        ext_req_i = 1'b0, ext_we_i = 1'b0;
    logic [3:0]  ext_be_i = 4'h3;
    logic [6:0]  ext_addr_i = '0;
    logic [31:0] ext_wdata_i = '0;
    logic        ext_gnt_o, ext_rvalid_o;
    logic [31:0] ext_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [6:0]  mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i = '0;
    logic        clr_stats_i = 1'b0;
    logic [15:0] stall_cnt_o;

    conv1d_mem_arbiter #(.AddrWidth(7), .DataWidth(32), .MaxWait(4)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .lock_i(lock_i),
        .acc_req_i(acc_req_i), .acc_we_i(acc_we_i), .acc_be_i(acc_be_i),
        .acc_addr_i(acc_addr_i), .acc_wdata_i(acc_wdata_i),
        .acc_gnt_o(acc_gnt_o), .acc_rvalid_o(acc_rvalid_o), .acc_rdata_o(acc_rdata_o),
        .ext_req_i(ext_req_i), .ext_we_i(ext_we_i), .ext_be_i(ext_be_i),
        .ext_addr_i(ext_addr_i), .ext_wdata_i(ext_wdata_i),
        .ext_gnt_o(ext_gnt_o), .ext_rvalid_o(ext_rvalid_o), .ext_rdata_o(ext_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
        .clr_stats_i(clr_stats_i), .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic        ext;
        logic [31:0] rd;
    } rsp_t;
    rsp_t rsp_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Per-cycle expectation set by the stimulus, compared by the monitor.
    logic        chk_en = 1'b0;
    logic        exp_ag, exp_eg, exp_we, exp_cs;
    logic [6:0]  exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [15:0] exp_stall;
    logic [31:0] next_rdata = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        logic        ea, ee;
        logic [31:0] ead, eed;
        rsp_t        r;
        ea = 1'b0; ee = 1'b0; ead = '0; eed = '0;
        while (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
            r = rsp_q.pop_front();
            if (r.due < cyc) begin
                chk("rsp_missing", 32'(r.due), 32'(cyc));
            end else if (r.ext) begin
                ee = 1'b1; eed = r.rd;
            end else begin
                ea = 1'b1; ead = r.rd;
            end
        end
        if (chk_en || acc_rvalid_o || ext_rvalid_o || ea || ee) begin
            chk("acc_rvalid", 32'(acc_rvalid_o), 32'(ea));
            chk("acc_rdata", acc_rdata_o, ead);
            chk("ext_rvalid", 32'(ext_rvalid_o), 32'(ee));
            chk("ext_rdata", ext_rdata_o, eed);
        end
        if (chk_en) begin
            chk("acc_gnt", 32'(acc_gnt_o), 32'(exp_ag));
            chk("ext_gnt", 32'(ext_gnt_o), 32'(exp_eg));
            chk("mem_req", 32'(mem_req_o), 32'(exp_ag | exp_eg));
            chk("mem_addr", 32'(mem_addr_o), 32'(exp_addr));
            chk("mem_we", 32'(mem_we_o), 32'(exp_we));
            chk("mem_be", 32'(mem_be_o), 32'(exp_be));
            chk("mem_wdata", mem_wdata_o, exp_wdata);
            if (exp_cs) chk("stall_cnt", 32'(stall_cnt_o), 32'(exp_stall));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        chk_en      = 1'b0;
        mem_rdata_i = next_rdata;
        next_rdata  = '0;
    endtask

    task automatic set_req(input logic ar, input logic [6:0] aa, input logic er, input logic [6:0] ea);
        acc_req_i   = ar;
        acc_addr_i  = aa;
        acc_wdata_i = 32'hAAAA0000 | 32'(aa);
        ext_req_i   = er;
        ext_addr_i  = ea;
        ext_wdata_i = 32'hEEEE0000 | 32'(ea);
    endtask

    // Expected bus contents follow from which side is granted; a grant also
    // schedules the response the SRAM model will return next cycle.
    task automatic expect_cyc(input logic ag, input logic eg, input logic cs,
                              input logic [15:0] sv, input logic [31:0] rd);
        exp_ag    = ag;
        exp_eg    = eg;
        exp_cs    = cs;
        exp_stall = sv;
        exp_addr  = ag ? acc_addr_i : (eg ? ext_addr_i : 7'd0);
        exp_we    = ag ? acc_we_i : (eg ? ext_we_i : 1'b0);
        exp_be    = ag ? 4'hF : (eg ? 4'h3 : 4'h0);
        exp_wdata = ag ? (32'hAAAA0000 | 32'(acc_addr_i)) :
                    (eg ? (32'hEEEE0000 | 32'(ext_addr_i)) : 32'h0);
        chk_en    = 1'b1;
        if (ag || eg) begin
            rsp_q.push_back('{due: cyc + 1, ext: eg, rd: rd});
            next_rdata = rd;
        end
    endtask

    initial begin
        int s;
        logic eg;

        // Reset with both requesting
        set_req(1, 7'd3, 1, 7'd9);
        tick();
        for (int i = 0; i < 2; i++) begin
            tick();
            expect_cyc(0, 0, 1, 16'd0, 32'h0);
        end
        tick(); rst_ni = 1'b1;
        expect_cyc(1, 0, 1, 16'd0, 32'h11111111);
        tick(); set_req(0, 0, 0, 0);
        expect_cyc(0, 0, 1, 16'd1, 32'h0);

        // Single external read
        tick(); set_req(0, 0, 1, 7'd5);
        expect_cyc(0, 1, 1, 16'd1, 32'hDEADBEEF);
        tick(); set_req(0, 0, 0, 0);
        expect_cyc(0, 0, 1, 16'd1, 32'h0);

        // Fairness: external wins every fifth cycle
        s = 1;
        for (int i = 0; i < 10; i++) begin
            tick(); set_req(1, 7'd1, 1, 7'd2);
            eg = (i == 4) || (i == 9);
            expect_cyc(!eg, eg, 1, 16'(s), 32'h100 + 32'(i));
            if (!eg) s++;
        end
        tick(); set_req(0, 0, 0, 0);
        expect_cyc(0, 0, 1, 16'(s), 32'h0);

        // Lock: external starves, then wins the cycle lock drops
        tick(); clr_stats_i = 1'b1;
        tick(); clr_stats_i = 1'b0; lock_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(); set_req(0, 0, 1, 7'd10);
            expect_cyc(0, 0, 1, 16'(i), 32'h0);
        end
        tick(); lock_i = 1'b0; set_req(0, 0, 1, 7'd11);
        expect_cyc(0, 1, 1, 16'd10, 32'h44);
        // Lock rises with an external response in flight
        tick(); lock_i = 1'b1; set_req(1, 7'd12, 0, 0);
        expect_cyc(1, 0, 1, 16'd10, 32'h45);

        // Back-to-back: external write then accelerator read
        tick(); lock_i = 1'b0; set_req(0, 0, 1, 7'd7); ext_we_i = 1'b1;
        expect_cyc(0, 1, 1, 16'd10, 32'h55);
        tick(); set_req(1, 7'd8, 0, 0); ext_we_i = 1'b0;
        expect_cyc(1, 0, 1, 16'd10, 32'h66);
        tick(); set_req(0, 0, 0, 0);
        expect_cyc(0, 0, 1, 16'd10, 32'h0);

        // Reset mid-transaction drops the pending response and clears wait_q
        tick(); set_req(1, 7'd20, 1, 7'd21);
        expect_cyc(1, 0, 0, 16'd0, 32'h77);
        tick();
        tick(); rst_ni = 1'b0; set_req(0, 0, 0, 0);
        expect_cyc(0, 0, 0, 16'd0, 32'h0);
        tick(); rst_ni = 1'b1; set_req(1, 7'd22, 1, 7'd23);
        for (int i = 0; i < 5; i++) begin
            eg = (i == 4);
            expect_cyc(!eg, eg, 1, 16'(i), 32'h80 + 32'(i));
            tick();
        end
        set_req(0, 0, 0, 0);
        expect_cyc(0, 0, 1, 16'd4, 32'h0);

        // Stall counter saturation and clear priority
        tick(); clr_stats_i = 1'b1;
        tick(); clr_stats_i = 1'b0; lock_i = 1'b1; set_req(0, 0, 1, 7'd30);
        for (int i = 0; i < 65540; i++) begin
            if (i >= 65534) expect_cyc(0, 0, 1, (i >= 65535) ? 16'hFFFF : 16'hFFFE, 32'h0);
            tick();
        end
        clr_stats_i = 1'b1;
        expect_cyc(0, 0, 1, 16'hFFFF, 32'h0);
        tick(); clr_stats_i = 1'b0;
        expect_cyc(0, 0, 1, 16'd0, 32'h0);
        tick();
        expect_cyc(0, 0, 1, 16'd1, 32'h0);
        tick(); lock_i = 1'b0; set_req(0, 0, 0, 0);
        tick();
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
